input_debouncer: RTL and testbench
==================================

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter STABLE_CYCLES, default 50000: consecutive synchronized cycles a new level must persist before the output follows it; legal range 2 to 2^CNT_WIDTH-1.
REQ-002 Parameter CNT_WIDTH, default 16: width of each channel's stability counter.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port A_raw, input, 1: asynchronous bouncy switch input, channel A.
REQ-006 Port B_raw, input, 1: asynchronous bouncy switch input, channel B.
REQ-007 Port A, output, 1: debounced level, channel A; drives the downstream 2-input gate input A.
REQ-008 Port B, output, 1: debounced level, channel B; drives the downstream gate input B.
REQ-009 Port A_rise, output, 1: one-cycle pulse when A goes 0->1.
REQ-010 Port B_rise, output, 1: one-cycle pulse when B goes 0->1.
REQ-011 Port A_fall, output, 1: one-cycle pulse when A goes 1->0.
REQ-012 Port B_fall, output, 1: one-cycle pulse when B goes 1->0.
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.

Function
REQ-014 Channels A and B SHALL be independent identical instances of the logic below; no cross-channel interaction.
REQ-015 Each raw input SHALL pass through a 2-flop synchronizer; sync-stage output is s.
REQ-016 Each channel SHALL run a 4-state FSM: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-017 STABLE_LO: s=0 -> stay, counter=0; s=1 -> PEND_HI, counter=1.
REQ-018 PEND_HI: s=0 -> STABLE_LO, counter=0 (glitch rejected, no output change); s=1 and counter<STABLE_CYCLES-1 -> counter+1; s=1 and counter=STABLE_CYCLES-1 -> STABLE_HI, output set to 1, counter=0.
REQ-019 STABLE_HI and PEND_LO SHALL mirror REQ-017/REQ-018 with levels inverted; the output clears to 0 on the transition PEND_LO->STABLE_HI... is not allowed: PEND_LO returns to STABLE_HI on s=1 and moves to STABLE_LO with output 0 on the terminal count.
REQ-020 The output SHALL equal 1 exactly when the state is STABLE_HI or PEND_LO.
REQ-021 Latency: with raw changed and held, first sampled at rising edge 1, the output SHALL change at rising edge STABLE_CYCLES+2, never earlier.
REQ-022 Any return of s to the current output level before terminal count SHALL reset the count to 0; partial counts never accumulate across glitches.
REQ-023 Rise/fall pulse SHALL assert for exactly the one cycle following the edge on which the output changes, and be 0 otherwise.
REQ-024 Rise and fall for one channel SHALL never assert together; A and B pulses MAY assert in the same cycle.
REQ-025 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.

Reset
REQ-026 While rst_n=0 at a rising edge: sync flops=0, state=STABLE_LO, counter=0, A=B=0, all pulses=0.
REQ-027 Reset mid-pending SHALL discard the partial count; after release a level held at 1 SHALL require a full STABLE_CYCLES+2 edges to reach the output.
REQ-028 Reset SHALL take priority over every other transition in the same cycle.

Verification (STABLE_CYCLES=4)
REQ-029 Reset, hold A_raw=1 from edge 1 -> A=0 through edge 5, A=1 after edge 6, A_rise=1 for that cycle only, A_fall=0.
REQ-030 A_raw pulses: 1 for 3 cycles, 0 for 1, repeat 5 times -> A stays 0, A_rise never asserts.
REQ-031 A=1 stable, drive A_raw=0 held -> A=0 after edge 6, A_fall one cycle; then A_raw=1 for 3 cycles only -> A remains 0.
REQ-032 A_raw and B_raw rise on the same edge -> A and B rise on the same edge, A_rise and B_rise both pulse in the same cycle.
REQ-033 A_raw=1 held, rst_n=0 at edge 4 for one cycle, released -> A rises exactly 6 edges after release, not earlier.
REQ-034 Random bounce on both channels for 10000 cycles -> scoreboard model matches A, B and all pulses cycle-exactly; counter never exceeds 3.

Source files
------------

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//   Two independent switch debouncers (channels A and B). Each raw input goes
//   through a 2-flop synchronizer and then a 4-state FSM. The debounced level
//   only follows a new synchronized level after that level has persisted for
//   STABLE_CYCLES consecutive cycles. A one-cycle rise/fall pulse accompanies
//   every change of the debounced level.
//
// Parameters
//   STABLE_CYCLES : cycles a new level must persist (2 .. 2**CNT_WIDTH-1)
//   CNT_WIDTH     : width of each channel's stability counter
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst_n        : synchronous active-low reset
//   A_raw, B_raw : asynchronous bouncy switch inputs
//   A, B         : debounced levels (registered)
//   A_rise/B_rise: one-cycle pulse in the cycle after A/B goes 0->1
//   A_fall/B_fall: one-cycle pulse in the cycle after A/B goes 1->0
// -----------------------------------------------------------------------------
module input_debouncer #(
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A_raw,
    input  logic B_raw,
    output logic A,
    output logic B,
    output logic A_rise,
    output logic B_rise,
    output logic A_fall,
    output logic B_fall
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    // Last count value before the level is accepted.
    localparam logic [CNT_WIDTH-1:0] TERM = CNT_WIDTH'(STABLE_CYCLES - 1);

    // Index 0 = channel A, index 1 = channel B.
    logic [1:0]           w_raw;
    logic [1:0]           r_sync1;
    logic [1:0]           r_sync2;
    state_t               r_state    [2];
    state_t               w_state_nxt[2];
    logic [CNT_WIDTH-1:0] r_cnt      [2];
    logic [CNT_WIDTH-1:0] w_cnt_nxt  [2];
    logic [1:0]           r_lvl;
    logic [1:0]           r_rise;
    logic [1:0]           r_fall;
    logic [1:0]           w_lvl_nxt;
    logic [1:0]           w_rise_nxt;
    logic [1:0]           w_fall_nxt;

    assign w_raw = {B_raw, A_raw};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_lvl   <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                r_state[ch] <= STABLE_LO;
                r_cnt[ch]   <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_lvl   <= w_lvl_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                r_state[ch] <= w_state_nxt[ch];
                r_cnt[ch]   <= w_cnt_nxt[ch];
            end
        end
    end

    always_comb begin
        w_lvl_nxt  = '0;
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            w_state_nxt[ch] = r_state[ch];
            w_cnt_nxt[ch]   = '0;
            case (r_state[ch])
                STABLE_LO: begin
                    if (r_sync2[ch]) begin
                        w_state_nxt[ch] = PEND_HI;
                        w_cnt_nxt[ch]   = CNT_WIDTH'(1);
                    end
                end
                PEND_HI: begin
                    if (!r_sync2[ch]) begin
                        w_state_nxt[ch] = STABLE_LO;
                    end else if (r_cnt[ch] == TERM) begin
                        w_state_nxt[ch] = STABLE_HI;
                    end else begin
                        w_cnt_nxt[ch] = r_cnt[ch] + CNT_WIDTH'(1);
                    end
                end
                STABLE_HI: begin
                    if (!r_sync2[ch]) begin
                        w_state_nxt[ch] = PEND_LO;
                        w_cnt_nxt[ch]   = CNT_WIDTH'(1);
                    end
                end
                PEND_LO: begin
                    if (r_sync2[ch]) begin
                        w_state_nxt[ch] = STABLE_HI;
                    end else if (r_cnt[ch] == TERM) begin
                        w_state_nxt[ch] = STABLE_LO;
                    end else begin
                        w_cnt_nxt[ch] = r_cnt[ch] + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    w_state_nxt[ch] = STABLE_LO;
                end
            endcase
            // Level is a registered decode of the next state, so pulses line
            // up with the cycle in which the registered level changes.
            w_lvl_nxt[ch]  = (w_state_nxt[ch] == STABLE_HI) ||
                             (w_state_nxt[ch] == PEND_LO);
            w_rise_nxt[ch] =  w_lvl_nxt[ch] & ~r_lvl[ch];
            w_fall_nxt[ch] = ~w_lvl_nxt[ch] &  r_lvl[ch];
        end
    end

    assign A      = r_lvl[0];
    assign B      = r_lvl[1];
    assign A_rise = r_rise[0];
    assign B_rise = r_rise[1];
    assign A_fall = r_fall[0];
    assign B_fall = r_fall[1];

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//   Directed checks of input_debouncer with STABLE_CYCLES=4, followed by a
//   random bounce run compared cycle-by-cycle against a run-length model.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

    localparam int SC = 4;

    logic clk;
    logic rst_n;
    logic A_raw, B_raw;
    logic A, B, A_rise, B_rise, A_fall, B_fall;

    int n_vec = 0;
    int n_err = 0;

    input_debouncer #(
        .STABLE_CYCLES(SC),
        .CNT_WIDTH    (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A_raw (A_raw),
        .B_raw (B_raw),
        .A     (A),
        .B     (B),
        .A_rise(A_rise),
        .B_rise(B_rise),
        .A_fall(A_fall),
        .B_fall(B_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the level flips once the synchronized input has
    // differed from it for SC consecutive cycles.
    logic [1:0] m_s1  = '0;
    logic [1:0] m_s2  = '0;
    logic [1:0] m_lvl = '0;
    logic [1:0] m_rise = '0;
    logic [1:0] m_fall = '0;
    int         m_run [2] = '{0, 0};

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1     <= '0;
            m_s2     <= '0;
            m_lvl    <= '0;
            m_rise   <= '0;
            m_fall   <= '0;
            m_run[0] <= 0;
            m_run[1] <= 0;
        end else begin
            m_s1 <= {B_raw, A_raw};
            m_s2 <= m_s1;
            for (int c = 0; c < 2; c++) begin
                if (m_s2[c] == m_lvl[c]) begin
                    m_run[c]  <= 0;
                    m_rise[c] <= 1'b0;
                    m_fall[c] <= 1'b0;
                end else if (m_run[c] + 1 == SC) begin
                    m_run[c]  <= 0;
                    m_lvl[c]  <= m_s2[c];
                    m_rise[c] <= m_s2[c];
                    m_fall[c] <= ~m_s2[c];
                end else begin
                    m_run[c]  <= m_run[c] + 1;
                    m_rise[c] <= 1'b0;
                    m_fall[c] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // Advance n rising edges, then stop on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [5:0] outs();
        return {A, B, A_rise, B_rise, A_fall, B_fall};
    endfunction

    initial begin
        rst_n = 1'b0;
        A_raw = 1'b1;
        B_raw = 1'b1;
        step(3);
        chk("reset_state", outs(), 6'b000000);

        // Release reset, hold A_raw=1 from edge 1: A changes at edge 6.
        A_raw = 1'b0;
        B_raw = 1'b0;
        rst_n = 1'b1;
        step(4);
        A_raw = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk("rise_latency_hold", outs(), 6'b000000);
        end
        step(1);
        chk("rise_edge6", outs(), 6'b101000);
        step(1);
        chk("rise_pulse_end", outs(), 6'b100000);

        // Drop A_raw: A falls at edge 6 with a one-cycle fall pulse.
        A_raw = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk("fall_latency_hold", outs(), 6'b100000);
        end
        step(1);
        chk("fall_edge6", outs(), 6'b000010);
        step(1);
        chk("fall_pulse_end", outs(), 6'b000000);

        // Three-cycle high burst is one short of acceptance.
        A_raw = 1'b1;
        step(3);
        A_raw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk("short_burst", outs(), 6'b000000);
        end

        // 3-high / 1-low bounce: partial counts must not accumulate.
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) begin
                A_raw = (k < 3);
                step(1);
                chk("bounce_reject", outs(), 6'b000000);
            end
        end
        A_raw = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("bounce_settle", outs(), 6'b000000);
        end

        // Both channels rise together.
        A_raw = 1'b1;
        B_raw = 1'b1;
        step(5);
        chk("dual_pre", outs(), 6'b000000);
        step(1);
        chk("dual_rise", outs(), 6'b111100);
        step(1);
        chk("dual_steady", outs(), 6'b110000);

        // Both fall together.
        A_raw = 1'b0;
        B_raw = 1'b0;
        step(6);
        chk("dual_fall", outs(), 6'b000011);
        step(3);
        chk("dual_low", outs(), 6'b000000);

        // Reset mid-pending discards the partial count.
        A_raw = 1'b1;
        step(3);
        rst_n = 1'b0;
        step(1);
        chk("mid_reset", outs(), 6'b000000);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk("post_reset_hold", outs(), 6'b000000);
        end
        step(1);
        chk("post_reset_rise", outs(), 6'b101000);

        // Reset while A=1 clears level without a fall pulse.
        step(2);
        chk("pre_reset_high", outs(), 6'b100000);
        rst_n = 1'b0;
        step(1);
        chk("reset_priority", outs(), 6'b000000);
        rst_n = 1'b1;
        A_raw = 1'b0;
        step(2);

        // Random bounce on both channels against the model.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if ($urandom_range(0, 5) == 0) A_raw = ~A_raw;
            if ($urandom_range(0, 4) == 0) B_raw = ~B_raw;
            rst_n = ($urandom_range(0, 999) != 0);
            step(1);
            chk("rand_model", outs(), {m_lvl[0], m_lvl[1], m_rise[0], m_rise[1], m_fall[0], m_fall[1]});
            chk("rand_excl", 6'({A_rise & A_fall, B_rise & B_fall}), 6'b000000);
            chk("rand_cnt", 6'({dut.r_cnt[0] <= 3'd3, dut.r_cnt[1] <= 3'd3}), 6'b000011);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
